hash_job_arbiter: RTL and testbench

HASH_JOB_ARBITER -- requirements
Module: hash_job_arbiter

---
 rtl/hash_job_arbiter_pkg.sv | 13 +
 rtl/job_owner_fifo.sv | 43 ++++
 rtl/hash_job_arbiter.sv | 131 +++++++++++++
 tb/tb_hash_job_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_job_arbiter_pkg.sv
`default_nettype none
// hash_job_arbiter_pkg: shared issue width and FSM encoding for the hash job arbiter.
package hash_job_arbiter_pkg;

  localparam int HASH_ISSUE_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/job_owner_fifo.sv
`default_nettype none
// job_owner_fifo: synchronous FIFO of requester ids, one entry per job in flight in the engine.
module job_owner_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/hash_job_arbiter.sv
`default_nettype none
// hash_job_arbiter: round-robin job-level arbiter feeding one hash engine, with owner
// tracking of in-flight jobs so engine results can be routed back to their requester.
module hash_job_arbiter
  import hash_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int OWNER_FIFO_DEPTH = 8,
  localparam int NUM_REQ_LOG2    = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_delim,
  input  logic [NUM_REQ*HASH_ISSUE_WIDTH*8-1:0] req_data,
  output logic                                 eng_valid,
  input  logic                                 eng_ready,
  output logic                                 eng_delim,
  output logic [HASH_ISSUE_WIDTH*8-1:0]        eng_data,
  input  logic                                 eng_out_valid,
  input  logic                                 eng_out_ready,
  input  logic                                 eng_out_delim,
  output logic                                 res_owner_valid,
  output logic [NUM_REQ_LOG2-1:0]              res_owner,
  output logic                                 busy,
  output logic                                 err_orphan
);

  localparam int DW = HASH_ISSUE_WIDTH * 8;

  arb_state_e              state;
  arb_state_e              state_next;
  logic [NUM_REQ_LOG2-1:0] rr_ptr;
  logic [NUM_REQ_LOG2-1:0] grant_id;
  logic [NUM_REQ_LOG2-1:0] pick_id;
  logic [NUM_REQ_LOG2-1:0] cand;
  logic                    pick_found;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    job_done;
  logic [NUM_REQ_LOG2-1:0] fifo_head;

  // Round-robin search starting at rr_ptr; index arithmetic wraps because NUM_REQ is 2^n.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + NUM_REQ_LOG2'(k);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    eng_valid  = 1'b0;
    eng_delim  = 1'b0;
    eng_data   = '0;
    req_ready  = '0;
    fifo_push  = 1'b0;
    job_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          fifo_push  = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        eng_valid           = req_valid[grant_id];
        eng_delim           = req_delim[grant_id];
        eng_data            = req_data[int'(grant_id)*DW +: DW];
        req_ready[grant_id] = eng_ready;
        if (eng_valid && eng_ready && eng_delim) begin
          job_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      if (fifo_push) grant_id <= pick_id;
      if (job_done)  rr_ptr   <= grant_id + NUM_REQ_LOG2'(1);
    end
  end

  // Any engine output handshake with nobody recorded means the owner tracking lost sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            err_orphan <= 1'b0;
    else if (eng_out_valid && eng_out_ready && fifo_empty) err_orphan <= 1'b1;
  end

  assign fifo_pop = eng_out_valid && eng_out_ready && eng_out_delim && !fifo_empty;

  job_owner_fifo #(
    .WIDTH (NUM_REQ_LOG2),
    .DEPTH (OWNER_FIFO_DEPTH)
  ) u_owner_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (pick_id),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (fifo_head)
  );

  assign res_owner_valid = !fifo_empty;
  assign res_owner       = fifo_head;
  assign busy            = (state != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_hash_job_arbiter.sv
`default_nettype none
// tb_hash_job_arbiter: directed scenarios plus randomized traffic checked against a queue-based job model.
module tb_hash_job_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_delim;
  logic [N*DW-1:0] req_data;
  logic            eng_valid;
  logic            eng_ready;
  logic            eng_delim;
  logic [DW-1:0]   eng_data;
  logic            eng_out_valid;
  logic            eng_out_ready;
  logic            eng_out_delim;
  logic            res_owner_valid;
  logic [1:0]      res_owner;
  logic            busy;
  logic            err_orphan;

  hash_job_arbiter #(.NUM_REQ(N), .OWNER_FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_delim       (req_delim),
    .req_data        (req_data),
    .eng_valid       (eng_valid),
    .eng_ready       (eng_ready),
    .eng_delim       (eng_delim),
    .eng_data        (eng_data),
    .eng_out_valid   (eng_out_valid),
    .eng_out_ready   (eng_out_ready),
    .eng_out_delim   (eng_out_delim),
    .res_owner_valid (res_owner_valid),
    .res_owner       (res_owner),
    .busy            (busy),
    .err_orphan      (err_orphan)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Job-level model: who holds the engine (-1 = nobody), next search start, owners in flight.
  int m_owner;
  int m_rr;
  int m_q[$];
  bit m_orphan;

  // Requester stimulus: beats left in the current job per requester.
  int rem[N];
  bit reload;
  bit drop_en;
  int cyc;

  // Observations taken from the engine-side port.
  int glog[$];
  int clog[$];
  int blog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_rr     = 0;
    m_q      = {};
    m_orphan = 1'b0;
  endtask

  task automatic clear_logs();
    glog = {};
    clog = {};
    blog = {};
  endtask

  // One clock cycle: drive requesters, compare outputs to the model, advance model and stimulus.
  task automatic step();
    logic [N-1:0]  exp_ready;
    logic          exp_ev;
    logic          exp_ed;
    logic [DW-1:0] exp_data;
    bit            acc_delim;
    bit            pop;
    bit            orph;
    int            pick;
    if (!rst_n) model_reset();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (rem[i] > 0) && !(drop_en && ($urandom_range(0, 3) == 0));
      req_delim[i]           = (rem[i] == 1);
      req_data[i*DW +: DW]   = {8'(i), 8'(rem[i]), 16'($urandom)};
    end
    #1;
    exp_ready = '0;
    exp_ev    = 1'b0;
    exp_ed    = 1'b0;
    exp_data  = '0;
    if (m_owner >= 0) begin
      exp_ev             = req_valid[m_owner];
      exp_ed             = req_delim[m_owner];
      exp_data           = req_data[m_owner*DW +: DW];
      exp_ready[m_owner] = eng_ready;
    end
    check("eng_valid", 64'(eng_valid), 64'(exp_ev));
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (exp_ev) begin
      check("eng_delim", 64'(eng_delim), 64'(exp_ed));
      check("eng_data", 64'(eng_data), 64'(exp_data));
    end
    check("res_owner_valid", 64'(res_owner_valid), 64'(m_q.size() > 0));
    check("res_owner", 64'(res_owner), (m_q.size() > 0) ? 64'(m_q[0]) : 64'(0));
    check("busy", 64'(busy), 64'((m_owner >= 0) || (m_q.size() > 0)));
    check("err_orphan", 64'(err_orphan), 64'(m_orphan));

    if (eng_valid && eng_ready) begin
      blog.push_back(int'(eng_data[23:16]));
      if (eng_delim) begin
        glog.push_back(int'(eng_data[31:24]));
        clog.push_back(cyc);
      end
    end

    if (rst_n) begin
      acc_delim = (m_owner >= 0) && exp_ev && eng_ready && exp_ed;
      pop  = eng_out_valid && eng_out_ready && eng_out_delim && (m_q.size() > 0);
      orph = eng_out_valid && eng_out_ready && (m_q.size() == 0);
      pick = -1;
      if (m_owner < 0 && m_q.size() < DEPTH)
        for (int k = 0; k < N; k++)
          if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
      if (pop) void'(m_q.pop_front());
      if (orph) m_orphan = 1'b1;
      if (pick >= 0) begin
        m_q.push_back(pick);
        m_owner = pick;
      end else if (acc_delim) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_ready[i]) begin
          rem[i]--;
          if (rem[i] == 0 && reload) rem[i] = 1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    reload        = 1'b0;
    drop_en       = 1'b0;
    eng_ready     = 1'b1;
    eng_out_valid = 1'b0;
    eng_out_ready = 1'b0;
    eng_out_delim = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    clear_logs();
  endtask

  initial begin
    req_valid     = '0;
    req_delim     = '0;
    req_data      = '0;
    eng_ready     = 1'b1;
    eng_out_valid = 1'b0;
    eng_out_ready = 1'b0;
    eng_out_delim = 1'b0;
    reload        = 1'b0;
    drop_en       = 1'b0;
    cyc           = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Single 3-beat job from requester 2, then a 0-vs-3 contest shows rr_ptr moved to 3.
    rem[2] = 3;
    for (int c = 0; c < 5; c++) step();
    check("s1_beats", 64'(blog.size()), 64'(3));
    if (blog.size() == 3) begin
      check("s1_beat0", 64'(blog[0]), 64'(3));
      check("s1_beat2", 64'(blog[2]), 64'(1));
    end
    check("s1_owner", 64'(res_owner), 64'(2));
    rem[0] = 1;
    rem[3] = 1;
    for (int c = 0; c < 4; c++) step();
    check("s1_rr_count", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) begin
      check("s1_rr_first", 64'(glog[1]), 64'(3));
      check("s1_rr_second", 64'(glog[2]), 64'(0));
    end

    // All requesters always valid with 1-beat jobs: strict rotation, one idle cycle between jobs.
    do_reset();
    reload = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 10; c++) step();
    check("s2_count", 64'(glog.size()), 64'(5));
    for (int j = 0; j < 5; j++) begin
      if (j < glog.size()) check("s2_order", 64'(glog[j]), 64'(j % N));
      if (j > 0 && j < clog.size()) check("s2_gap", 64'(clog[j] - clog[j-1]), 64'(2));
    end

    // Backpressure on a 4-beat job from requester 1.
    do_reset();
    rem[1] = 4;
    for (int c = 0; c < 20 && blog.size() < 4; c++) begin
      eng_ready = c[0];
      step();
    end
    eng_ready = 1'b1;
    check("s3_beats", 64'(blog.size()), 64'(4));
    for (int j = 0; j < 4 && j < blog.size(); j++) check("s3_order", 64'(blog[j]), 64'(4 - j));

    // Owner FIFO full: ninth grant held until one result pops, then granted the next cycle.
    do_reset();
    reload = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 16; c++) step();
    check("s4_eight", 64'(glog.size()), 64'(8));
    for (int c = 0; c < 3; c++) step();
    check("s4_held", 64'(glog.size()), 64'(8));
    eng_out_valid = 1'b1;
    eng_out_ready = 1'b1;
    eng_out_delim = 1'b1;
    step();
    eng_out_valid = 1'b0;
    eng_out_ready = 1'b0;
    eng_out_delim = 1'b0;
    check("s4_after_pop", 64'(glog.size()), 64'(8));
    step();
    check("s4_grant_cycle", 64'(glog.size()), 64'(8));
    step();
    check("s4_ninth", 64'(glog.size()), 64'(9));
    reload = 1'b0;

    // Orphan detection, then asynchronous reset in the middle of a job.
    do_reset();
    eng_out_valid = 1'b1;
    eng_out_ready = 1'b1;
    step();
    eng_out_valid = 1'b0;
    eng_out_ready = 1'b0;
    step();
    check("s5_orphan", 64'(err_orphan), 64'(1));
    rem[2] = 1;
    step();
    step();
    rem[3] = 5;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("s5_rst_valid", 64'(eng_valid), 64'(0));
    check("s5_rst_busy", 64'(busy), 64'(0));
    check("s5_rst_orphan", 64'(err_orphan), 64'(0));
    for (int i = 0; i < N; i++) rem[i] = 0;
    rst_n = 1'b1;
    clear_logs();
    rem[1] = 1;
    rem[3] = 1;
    step();
    step();
    check("s5_post_count", 64'(glog.size()), 64'(1));
    if (glog.size() > 0) check("s5_post_owner", 64'(glog[0]), 64'(1));

    // Randomized traffic: variable job lengths, mid-job valid drops, random engine handshakes.
    do_reset();
    drop_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 4);
      eng_ready     = 1'($urandom_range(0, 3) != 0);
      eng_out_valid = 1'($urandom_range(0, 9) < 3);
      eng_out_ready = 1'($urandom_range(0, 1));
      eng_out_delim = 1'($urandom_range(0, 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
